// File: rtl/screen_pkg.sv
// Shared types and defaults for the LED screen row scanner.
package screen_pkg;

  localparam int ROWS_DEF  = 6;
  localparam int COLS_DEF  = 8;
  localparam int ROW_W_DEF = $clog2(ROWS_DEF);

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_t;

  // Width able to hold max(a,b)-1; at least one bit.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/row_scan_timer.sv
// Row scan sequencer: alternates an all-off BLANK gap and a lit SHOW window
// for each row in turn, and flags when the next row's byte must be latched.
module row_scan_timer
  import screen_pkg::*;
#(
  parameter int ROWS         = ROWS_DEF,
  parameter int SCAN_DIV     = 12000,
  parameter int BLANK_CYCLES = 120,
  parameter int ROW_W        = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  output logic             latch,
  output logic [ROW_W-1:0] row,
  output logic             show,
  output logic             frame_start
);

  localparam int CNT_W = cnt_width(SCAN_DIV, BLANK_CYCLES);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(ROWS - 1);

  scan_state_t      state;
  logic [CNT_W-1:0] cnt;

  // State, in-state cycle count and row index advance together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= BLANK;
      cnt   <= '0;
      row   <= '0;
    end else begin
      case (state)
        BLANK: begin
          if (cnt == BLANK_LAST) begin
            state <= SHOW;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        SHOW: begin
          if (cnt == SHOW_LAST) begin
            state <= BLANK;
            cnt   <= '0;
            row   <= (row == ROW_LAST) ? '0 : row + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= BLANK;
          cnt   <= '0;
        end
      endcase
    end
  end

  // The byte shown in SHOW is captured on the last BLANK cycle of that row.
  assign latch       = (state == BLANK) && (cnt == BLANK_LAST);
  assign show        = (state == SHOW);
  assign frame_start = (state == SHOW) && (row == '0) && (cnt == '0);

endmodule

// File: rtl/led_screen_scanner.sv
// LED matrix driver: one byte per row held in a small register file, rows
// lit one at a time with a blanking gap in between to avoid ghosting.
module led_screen_scanner
  import screen_pkg::*;
#(
  parameter int ROWS           = ROWS_DEF,
  parameter int COLS           = COLS_DEF,
  parameter int SCAN_DIV       = 12000,
  parameter int BLANK_CYCLES   = 120,
  parameter bit ROW_ACTIVE_LOW = 1'b0,
  parameter bit COL_ACTIVE_LOW = 1'b0,
  localparam int ROW_W         = $clog2(ROWS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  output logic [ROWS-1:0]  row_sel,
  output logic [COLS-1:0]  col_out,
  output logic             frame_start
);

  logic [COLS-1:0]  screen_buf [ROWS];
  logic [COLS-1:0]  col_q;
  logic             latch;
  logic             show;
  logic [ROW_W-1:0] row;
  logic             wr_ok;
  logic [ROWS-1:0]  row_onehot;
  logic [COLS-1:0]  col_pat;

  row_scan_timer #(
    .ROWS        (ROWS),
    .SCAN_DIV    (SCAN_DIV),
    .BLANK_CYCLES(BLANK_CYCLES),
    .ROW_W       (ROW_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .latch      (latch),
    .row        (row),
    .show       (show),
    .frame_start(frame_start)
  );

  // Out-of-range row indices are dropped without effect.
  assign wr_ok = ({1'b0, wr_row} < (ROW_W + 1)'(ROWS));

  // Row byte storage; cleared by reset so a reset always yields a dark frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < ROWS; r++) screen_buf[r] <= '0;
    end else if (wr_en && wr_ok) begin
      screen_buf[wr_row] <= wr_data;
    end
  end

  // Latch the row byte once per row so mid-SHOW writes never tear the display;
  // a same-cycle write to that row lands after the latch reads the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q <= '0;
    end else if (latch) begin
      col_q <= screen_buf[row];
    end
  end

  // Logical drive pattern: only the current row and its byte during SHOW.
  always_comb begin
    row_onehot = '0;
    col_pat    = '0;
    if (show) begin
      row_onehot[row] = 1'b1;
      col_pat         = col_q;
    end
  end

  assign row_sel = row_onehot ^ {ROWS{ROW_ACTIVE_LOW}};
  assign col_out = col_pat ^ {COLS{COL_ACTIVE_LOW}};

endmodule

// File: tb/tb_led_screen_scanner.sv
// Directed bench for led_screen_scanner with short scan timing.
module tb_led_screen_scanner;

  localparam int ROWS = 6;
  localparam int COLS = 8;
  localparam int SD   = 4;
  localparam int BC   = 2;
  localparam int SLOT = SD + BC;
  localparam int PER  = ROWS * SLOT;

  logic            clk = 1'b0;
  logic            rst;
  logic            wr_en;
  logic [2:0]      wr_row;
  logic [COLS-1:0] wr_data;
  logic [ROWS-1:0] row_sel, row_sel_n;
  logic [COLS-1:0] col_out, col_out_n;
  logic            fs, fs_n;

  int checks   = 0;
  int failures = 0;
  logic [COLS-1:0] exp_mem [ROWS];

  always #5 clk = ~clk;

  led_screen_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .ROW_ACTIVE_LOW(1'b0), .COL_ACTIVE_LOW(1'b0)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .row_sel(row_sel), .col_out(col_out), .frame_start(fs)
  );

  led_screen_scanner #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .BLANK_CYCLES(BC),
    .ROW_ACTIVE_LOW(1'b1), .COL_ACTIVE_LOW(1'b1)
  ) dut_n (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_row(wr_row), .wr_data(wr_data),
    .row_sel(row_sel_n), .col_out(col_out_n), .frame_start(fs_n)
  );

  // Expected (active-high) outputs for cycle c counted from reset release.
  function automatic logic [ROWS-1:0] m_row(input int c);
    int p;
    p = c % PER;
    if ((p % SLOT) < BC) return '0;
    return ROWS'(1 << (p / SLOT));
  endfunction

  function automatic logic [COLS-1:0] m_col(input int c);
    int p;
    p = c % PER;
    if ((p % SLOT) < BC) return '0;
    return exp_mem[p / SLOT];
  endfunction

  function automatic logic m_fs(input int c);
    return (c % PER) == BC;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_model();
    for (int r = 0; r < ROWS; r++) exp_mem[r] = '0;
  endtask

  task automatic do_reset();
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    tick();
    rst = 1'b0;
  endtask

  task automatic drive_wr(input logic [2:0] r, input logic [7:0] d);
    wr_en = 1'b1; wr_row = r; wr_data = d;
  endtask

  task automatic test_reset();
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    tick(); tick();
    checks++;
    if (row_sel !== 6'h00 || col_out !== 8'h00 || fs !== 1'b0) begin
      failures++;
      $display("FAIL reset_state row_sel=%h col_out=%h fs=%b required 00/00/0", row_sel, col_out, fs);
    end
    checks++;
    if (row_sel_n !== 6'h3F || col_out_n !== 8'hFF || fs_n !== 1'b0) begin
      failures++;
      $display("FAIL reset_state_inv row_sel=%h col_out=%h fs=%b required 3f/ff/0", row_sel_n, col_out_n, fs_n);
    end
    rst = 1'b0;
  endtask

  task automatic test_scan_idle();
    do_reset(); clear_model();
    for (int c = 0; c <= 75; c++) begin
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c) || fs !== m_fs(c)) begin
        failures++;
        $display("FAIL scan_idle cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel, col_out, fs, m_row(c), m_col(c), m_fs(c));
      end
      tick();
    end
  endtask

  task automatic test_write_display();
    do_reset(); clear_model();
    exp_mem[2] = 8'hA5; exp_mem[5] = 8'h3C;
    for (int c = 0; c <= 35; c++) begin
      wr_en = 1'b0;
      if (c == 0) drive_wr(3'd2, 8'hA5);
      if (c == 1) drive_wr(3'd5, 8'h3C);
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c) || fs !== m_fs(c)) begin
        failures++;
        $display("FAIL write_display cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel, col_out, fs, m_row(c), m_col(c), m_fs(c));
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_write_while_lit();
    do_reset(); clear_model();
    exp_mem[0] = 8'h11;
    for (int c = 0; c <= 47; c++) begin
      wr_en = 1'b0;
      if (c == 0) drive_wr(3'd0, 8'h11);
      if (c == 3) drive_wr(3'd0, 8'hFF);  // row 0 is lit right now
      if (c == 7) drive_wr(3'd1, 8'h22);  // same cycle as row 1 latch
      if (c == 36) begin
        exp_mem[0] = 8'hFF;
        exp_mem[1] = 8'h22;
      end
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c) || fs !== m_fs(c)) begin
        failures++;
        $display("FAIL write_while_lit cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel, col_out, fs, m_row(c), m_col(c), m_fs(c));
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_bad_row();
    do_reset(); clear_model();
    for (int c = 0; c <= 35; c++) begin
      wr_en = 1'b0;
      if (c == 0) drive_wr(3'd6, 8'hFF);
      if (c == 1) drive_wr(3'd7, 8'hFF);
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c)) begin
        failures++;
        $display("FAIL bad_row cyc=%0d got row_sel=%b col=%h required %b %h",
                 c, row_sel, col_out, m_row(c), m_col(c));
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  task automatic test_mid_reset();
    do_reset(); clear_model();
    exp_mem[0] = 8'h55; exp_mem[3] = 8'h77;
    for (int c = 0; c <= 21; c++) begin
      wr_en = 1'b0;
      if (c == 0) drive_wr(3'd0, 8'h55);
      if (c == 1) drive_wr(3'd3, 8'h77);
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c) || fs !== m_fs(c)) begin
        failures++;
        $display("FAIL mid_reset_pre cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel, col_out, fs, m_row(c), m_col(c), m_fs(c));
      end
      if (c < 21) tick();
    end
    // Cycle 21 is mid-SHOW of row 3; reset is sampled on the next edge.
    rst = 1'b1; wr_en = 1'b0;
    tick();
    rst = 1'b0;
    clear_model();
    for (int c = 0; c <= 38; c++) begin
      checks++;
      if (row_sel !== m_row(c) || col_out !== m_col(c) || fs !== m_fs(c)) begin
        failures++;
        $display("FAIL mid_reset_post cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel, col_out, fs, m_row(c), m_col(c), m_fs(c));
      end
      tick();
    end
  endtask

  task automatic test_polarity();
    do_reset(); clear_model();
    exp_mem[1] = 8'h0F;
    for (int c = 0; c <= 13; c++) begin
      wr_en = 1'b0;
      if (c == 0) drive_wr(3'd1, 8'h0F);
      checks++;
      if (row_sel_n !== (m_row(c) ^ 6'h3F) || col_out_n !== (m_col(c) ^ 8'hFF) || fs_n !== m_fs(c)) begin
        failures++;
        $display("FAIL polarity cyc=%0d got row_sel=%b col=%h fs=%b required %b %h %b",
                 c, row_sel_n, col_out_n, fs_n, m_row(c) ^ 6'h3F, m_col(c) ^ 8'hFF, m_fs(c));
      end
      tick();
    end
    wr_en = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_row = '0; wr_data = '0;
    test_reset();
    test_scan_idle();
    test_write_display();
    test_write_while_lit();
    test_bad_row();
    test_mid_reset();
    test_polarity();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
